// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch stage: next-PC select encodings, fetch FSM states
// and the payload carried by the IF/ID output register.
package fetch_pkg;
   localparam int unsigned XLEN_W      = 32;
   localparam int unsigned PCSRC_W     = 2;
   localparam int unsigned INSTR_BYTES = 4;

   localparam logic [PCSRC_W-1:0] PCSRC_SEQ   = 2'b00;
   localparam logic [PCSRC_W-1:0] PCSRC_JUMP  = 2'b01;
   localparam logic [PCSRC_W-1:0] PCSRC_FLUSH = 2'b10;

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_HOLD
   } fetch_state_t;

   typedef struct packed {
      logic [XLEN_W-1:0] pc;
      logic [XLEN_W-1:0] instr;
   } if_payload_t;
endpackage

// File: rtl/next_pc_mux.sv
// Decodes pcsrc into a redirect flag and a word-aligned redirect target.
module next_pc_mux
   import fetch_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic [PCSRC_W-1:0] pcsrc,
   input  logic [XLEN-1:0]    pc_q,
   input  logic [XLEN-1:0]    j_addr,
   input  logic [XLEN-1:0]    flush_addr,
   output logic [XLEN-1:0]    next_pc,
   output logic               redirect
);
   logic [XLEN-1:0] target;

   // Reserved encoding 11 falls through to sequential
   always_comb begin
      redirect = 1'b0;
      target   = pc_q;
      case (pcsrc)
         PCSRC_JUMP: begin
            redirect = 1'b1;
            target   = j_addr;
         end
         PCSRC_FLUSH: begin
            redirect = 1'b1;
            target   = flush_addr;
         end
         default: ;
      endcase
      next_pc = {target[XLEN-1:2], 2'b00};
   end
endmodule

// File: rtl/fetch_pc_unit.sv
// Owns the architectural PC, issues single-outstanding imem fetches and delivers
// instructions to decode through a one-entry valid/ready output register.
module fetch_pc_unit
   import fetch_pkg::*;
#(
   parameter int unsigned     XLEN         = 32,
   parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [PCSRC_W-1:0] pcsrc,
   input  logic [XLEN-1:0]    j_addr,
   input  logic [XLEN-1:0]    flush_addr,
   output logic               imem_req_valid,
   output logic [XLEN-1:0]    imem_req_addr,
   input  logic               imem_req_ready,
   input  logic               imem_rsp_valid,
   input  logic [XLEN-1:0]    imem_rsp_data,
   output logic               if_valid,
   output logic [XLEN-1:0]    if_instr,
   output logic [XLEN-1:0]    if_pc,
   input  logic               id_ready
);
   fetch_state_t    state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d, next_pc;
   logic            kill_q, kill_d;
   logic            redirect, load_c;
   if_payload_t     if_q;

   next_pc_mux #(.XLEN(XLEN)) u_next_pc_mux (
      .pcsrc      (pcsrc),
      .pc_q       (pc_q),
      .j_addr     (j_addr),
      .flush_addr (flush_addr),
      .next_pc    (next_pc),
      .redirect   (redirect)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: state_d = S_REQ;
         S_REQ:  if (imem_req_ready) state_d = S_WAIT;
         S_WAIT: if (imem_rsp_valid) state_d = (kill_q || redirect) ? S_REQ : S_HOLD;
         S_HOLD: if (!if_valid || id_ready || redirect) state_d = S_REQ;
         default: state_d = S_IDLE;
      endcase
   end

   // A redirect always wins over a sequential advance; responses are only looked at in S_WAIT
   always_comb begin
      imem_req_valid = 1'b0;
      imem_req_addr  = '0;
      load_c         = 1'b0;
      kill_d         = kill_q;
      case (state_q)
         S_REQ: begin
            imem_req_valid = 1'b1;
            imem_req_addr  = pc_q;
            if (imem_req_ready) kill_d = redirect;
         end
         S_WAIT: begin
            if (imem_rsp_valid) begin
               kill_d = 1'b0;
               load_c = !kill_q && !redirect;
            end else if (redirect) begin
               kill_d = 1'b1;
            end
         end
         default: ;
      endcase
      if (redirect)    pc_d = next_pc;
      else if (load_c) pc_d = pc_q + XLEN'(INSTR_BYTES);
      else             pc_d = pc_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q     <= RESET_VECTOR;
         kill_q   <= 1'b0;
         if_valid <= 1'b0;
         if_q     <= '0;
      end else begin
         pc_q   <= pc_d;
         kill_q <= kill_d;
         if (load_c) begin
            if_valid <= 1'b1;
            if_q     <= '{pc: pc_q, instr: imem_rsp_data};
         end else if (redirect || id_ready) begin
            if_valid <= 1'b0;
         end
      end
   end

   assign if_pc    = if_q.pc;
   assign if_instr = if_q.instr;
endmodule

// File: tb/tb_fetch_pc_unit.sv
// Scoreboarded bench for fetch_pc_unit: directed redirect/backpressure/wrap/reset cases
// against a 1-cycle instruction memory model.
module tb_fetch_pc_unit;
   logic        clk = 1'b0;
   logic        rst_n;
   logic [1:0]  pcsrc;
   logic [31:0] j_addr, flush_addr;
   logic        imem_req_valid;
   logic [31:0] imem_req_addr;
   logic        imem_req_ready;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        if_valid;
   logic [31:0] if_instr, if_pc;
   logic        id_ready;

   int checks = 0;
   int errors = 0;

   logic [31:0] exp_req[$];
   logic [63:0] exp_out[$];

   logic        pending = 1'b0;
   logic [31:0] pend_addr = '0;

   fetch_pc_unit #(.XLEN(32), .RESET_VECTOR(32'h0000_0000)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .pcsrc          (pcsrc),
      .j_addr         (j_addr),
      .flush_addr     (flush_addr),
      .imem_req_valid (imem_req_valid),
      .imem_req_addr  (imem_req_addr),
      .imem_req_ready (imem_req_ready),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .if_valid       (if_valid),
      .if_instr       (if_instr),
      .if_pc          (if_pc),
      .id_ready       (id_ready)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a + 32'h1000_0001;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_out_empty(input string name);
      int n = 0;
      while (exp_out.size() != 0 && n < 60) begin
         step();
         n++;
      end
      check({name, "_timeout"}, 32'(exp_out.size()), 32'd0);
   endtask

   // One-cycle memory: response presented in the cycle after the handshake
   initial begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
      forever begin
         @(negedge clk);
         imem_rsp_valid = pending;
         imem_rsp_data  = pending ? mem_word(pend_addr) : 32'h0;
         pending        = imem_req_valid && imem_req_ready;
         pend_addr      = imem_req_addr;
      end
   end

   // Scoreboard monitor: request addresses and delivered instructions
   initial begin
      logic [31:0] ea;
      logic [63:0] eo;
      forever begin
         @(negedge clk);
         if (rst_n && imem_req_valid && imem_req_ready) begin
            if (exp_req.size() == 0) begin
               check("unexpected_req", imem_req_addr, 32'hXXXX_XXXX);
            end else begin
               ea = exp_req.pop_front();
               check("req_addr", imem_req_addr, ea);
            end
         end
         if (rst_n && if_valid && id_ready) begin
            if (exp_out.size() == 0) begin
               check("unexpected_out", if_pc, 32'hXXXX_XXXX);
            end else begin
               eo = exp_out.pop_front();
               check("out_pc", if_pc, eo[63:32]);
               check("out_instr", if_instr, eo[31:0]);
            end
         end
      end
   end

   initial begin
      rst_n = 1'b0; pcsrc = 2'b00; j_addr = '0; flush_addr = '0;
      imem_req_ready = 1'b1; id_ready = 1'b1;
      #2;
      check("rst_if_valid", 32'(if_valid), 32'd0);
      check("rst_if_instr", if_instr, 32'h0);
      check("rst_if_pc", if_pc, 32'h0);
      check("rst_req_valid", 32'(imem_req_valid), 32'd0);
      check("rst_req_addr", imem_req_addr, 32'h0);

      // Sequential fetch from the reset vector
      for (int i = 0; i < 4; i++) begin
         exp_req.push_back(32'(i * 4));
         exp_out.push_back({32'(i * 4), mem_word(32'(i * 4))});
      end
      step(); step();
      rst_n = 1'b1;
      wait_out_empty("seq");
      imem_req_ready = 1'b0;
      check("seq_stall_addr", imem_req_addr, 32'h10);

      // Jump while the 0x10 fetch is in flight
      exp_req.push_back(32'h10);
      exp_req.push_back(32'h100);
      exp_out.push_back({32'h100, mem_word(32'h100)});
      imem_req_ready = 1'b1;
      step();
      pcsrc = 2'b01; j_addr = 32'h0000_0103;
      step();
      pcsrc = 2'b00;
      check("jmp_drop_valid", 32'(if_valid), 32'd0);
      check("jmp_req_valid", 32'(imem_req_valid), 32'd1);
      check("jmp_req_addr", imem_req_addr, 32'h100);
      wait_out_empty("jmp");

      // Flush redirect coincident with the 0x104 handshake
      exp_req.push_back(32'h104);
      exp_req.push_back(32'h40);
      exp_out.push_back({32'h40, mem_word(32'h40)});
      pcsrc = 2'b10; flush_addr = 32'h40;
      step();
      pcsrc = 2'b00;
      step();
      check("flush_drop_valid", 32'(if_valid), 32'd0);
      check("flush_req_addr", imem_req_addr, 32'h40);
      wait_out_empty("flush");

      // Backpressure on the 0x44 instruction
      exp_req.push_back(32'h44);
      exp_out.push_back({32'h44, mem_word(32'h44)});
      id_ready = 1'b0;
      step(); step();
      for (int i = 0; i < 5; i++) begin
         check("bp_valid", 32'(if_valid), 32'd1);
         check("bp_pc", if_pc, 32'h44);
         check("bp_instr", if_instr, mem_word(32'h44));
         check("bp_req_valid", 32'(imem_req_valid), 32'd0);
         step();
      end
      id_ready = 1'b1; imem_req_ready = 1'b0;
      step();
      check("bp_next_req_valid", 32'(imem_req_valid), 32'd1);
      check("bp_next_req_addr", imem_req_addr, 32'h48);
      check("bp_drained", 32'(exp_out.size()), 32'd0);

      // Wrap at the top of the address space with reserved pcsrc
      pcsrc = 2'b01; j_addr = 32'hFFFF_FFFF;
      step();
      check("wrap_req_addr", imem_req_addr, 32'hFFFF_FFFC);
      pcsrc = 2'b11; imem_req_ready = 1'b1;
      exp_req.push_back(32'hFFFF_FFFC);
      exp_out.push_back({32'hFFFF_FFFC, mem_word(32'hFFFF_FFFC)});
      wait_out_empty("wrap");
      check("wrap_next_addr", imem_req_addr, 32'h0);
      check("wrap_next_valid", 32'(imem_req_valid), 32'd1);
      imem_req_ready = 1'b0; pcsrc = 2'b00;
      step();

      // Reset while waiting for a response
      exp_req.push_back(32'h0);
      imem_req_ready = 1'b1;
      step();
      rst_n = 1'b0;
      #2;
      check("mrst_if_valid", 32'(if_valid), 32'd0);
      check("mrst_if_pc", if_pc, 32'h0);
      check("mrst_if_instr", if_instr, 32'h0);
      check("mrst_req_valid", 32'(imem_req_valid), 32'd0);
      check("mrst_req_addr", imem_req_addr, 32'h0);
      rst_n = 1'b1;
      exp_req.push_back(32'h0);
      exp_out.push_back({32'h0, mem_word(32'h0)});
      step();
      check("mrst_stale_valid", 32'(if_valid), 32'd0);
      wait_out_empty("mrst");
      imem_req_ready = 1'b0;
      step(); step();
      check("req_queue_empty", 32'(exp_req.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end
endmodule
